// File: rtl/score_recorder_if.sv
// Write port of the 128x8 score RAM: address {song, slot}, data {valid, pitch}, one-cycle strobe.
interface score_recorder_if;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       wren;

  modport master (output addr, wdata, wren);
  modport slave  (input  addr, wdata, wren);
endinterface

// File: rtl/score_recorder.sv
// Records keyboard notes into the score RAM, one word per beat, and ends every take with 8'h00.
// state | meaning
// IDLE  | waiting for record start; song select accepted
// ARM   | one cycle after start; pending note reset to rest
// REC   | one RAM word per beat; stop or slot 30 ends the take
// TERM  | writes the end marker and pulses done
module score_recorder #(
  parameter int         BEAT_DIV = 32768,
  parameter logic [1:0] DEF_SONG = 2'b01
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [4:0]         keybord,
  score_recorder_if.master   wr,
  output logic               recording,
  output logic               done,
  output logic [1:0]         song
);

  localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [7:0] REST = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_REC, S_TERM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       slot_q, slot_d;
  logic [7:0]       pend_q, pend_d;
  logic [1:0]       song_q, song_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wren_q, wren_d;
  logic             done_q, done_d;

  logic       is_start, is_stop, is_sel, is_note, tick;
  logic [7:0] note_word;

  assign is_start  = (keybord == 5'b11000);
  assign is_stop   = (keybord == 5'b11001);
  assign is_sel    = (keybord[4:2] == 3'b101);
  assign is_note   = !keybord[4] && (keybord[3:0] != 4'h0);
  assign note_word = {4'b1000, keybord[3:0]};
  assign tick      = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    slot_d  = slot_q;
    pend_d  = is_note ? note_word : pend_q;
    song_d  = song_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_sel) song_d = keybord[1:0];
        if (is_start) begin
          state_d = S_ARM;
          slot_d  = 5'd0;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        pend_d  = REST;
        state_d = S_REC;
      end
      S_REC: begin
        // A key on the tick cycle goes straight into this beat's word.
        if (tick) begin
          wren_d  = 1'b1;
          addr_d  = {song_q, slot_q};
          wdata_d = is_note ? note_word : pend_q;
          pend_d  = REST;
          slot_d  = slot_q + 5'd1;
          if (slot_q == 5'd30 || is_stop) state_d = S_TERM;
        end else if (is_stop) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        wren_d  = 1'b1;
        addr_d  = {song_q, slot_q};
        wdata_d = 8'h00;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot_q  <= 5'd0;
      pend_q  <= REST;
      song_q  <= DEF_SONG;
      addr_q  <= 7'h00;
      wdata_q <= 8'h00;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      song_q  <= song_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

  assign wr.addr   = addr_q;
  assign wr.wdata  = wdata_q;
  assign wr.wren   = wren_q;
  assign done      = done_q;
  assign song      = song_q;
  assign recording = (state_q == S_ARM) || (state_q == S_REC);

endmodule

// File: tb/tb_score_recorder.sv
// Bench for score_recorder: directed take scenarios plus random keyboard traffic against a beat-timeline model.
module tb_score_recorder;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] kb = 5'b00000;
  logic       recording, done;
  logic [1:0] song;

  score_recorder_if wr_bus ();

  score_recorder #(.BEAT_DIV(B), .DEF_SONG(2'b01)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keybord   (kb),
    .wr        (wr_bus),
    .recording (recording),
    .done      (done),
    .song      (song)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a take is a timeline counted from the start edge; every B-th edge is a beat write.
  bit         m_active, m_term_due, m_note;
  int         m_k, m_slot;
  logic [7:0] m_pend;
  logic [1:0] m_song;
  logic [6:0] e_addr;
  logic [7:0] e_wdata;
  logic       e_wren, e_done;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 0; m_term_due = 0; m_k = 0; m_slot = 0;
        m_pend = 8'h80; m_song = 2'b01;
        e_addr = 7'h00; e_wdata = 8'h00; e_wren = 1'b0; e_done = 1'b0;
      end else begin
        e_wren = 1'b0;
        e_done = 1'b0;
        m_note = (kb[4] == 1'b0) && (kb[3:0] != 4'h0);
        if (m_term_due) begin
          e_wren = 1'b1; e_done = 1'b1;
          e_addr = {m_song, m_slot[4:0]}; e_wdata = 8'h00;
          m_term_due = 0; m_active = 0;
        end else if (m_active) begin
          m_k++;
          if (m_k == 1) begin
            m_pend = 8'h80;
          end else if (m_k % B == 0) begin
            e_wren = 1'b1;
            e_addr = {m_song, m_slot[4:0]};
            e_wdata = m_note ? {4'b1000, kb[3:0]} : m_pend;
            m_pend = 8'h80;
            m_slot++;
            if (m_slot == 31 || kb == 5'b11001) m_term_due = 1;
          end else begin
            if (m_note) m_pend = {4'b1000, kb[3:0]};
            if (kb == 5'b11001) m_term_due = 1;
          end
        end else begin
          if (kb[4:2] == 3'b101) m_song = kb[1:0];
          if (kb == 5'b11000) begin
            m_active = 1; m_k = 0; m_slot = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("wren", 32'(wr_bus.wren), 32'(e_wren));
      chk("done", 32'(done), 32'(e_done));
      chk("addr", 32'(wr_bus.addr), 32'(e_addr));
      chk("wdata", 32'(wr_bus.wdata), 32'(e_wdata));
      chk("song", 32'(song), 32'(m_song));
      chk("recording", 32'(recording), 32'(m_active && !m_term_due));
    end
  end

  logic [14:0] wlog[$];
  int          wcyc[$];
  int          cyc_cnt = 0;
  int          done_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      if (wr_bus.wren === 1'b1) begin
        wlog.push_back({wr_bus.addr, wr_bus.wdata});
        wcyc.push_back(cyc_cnt);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic cyc(input logic [4:0] c);
    kb = c;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input logic [4:0] c, input string name);
    for (int i = 0; i < 300 && wlog.size() < n; i++) cyc(c);
    chk(name, 32'(wlog.size() >= n), 32'd1);
  endtask

  function automatic logic [4:0] rnd_code(input bit allow_stop);
    int r;
    logic [4:0] c;
    r = $urandom_range(0, 99);
    if (r < 8)                      c = 5'b11000;
    else if (r < 13 && allow_stop)  c = 5'b11001;
    else if (r < 50)                c = {1'b0, 4'($urandom_range(1, 15))};
    else if (r < 80)                c = 5'b00000;
    else if (r < 90)                c = {3'b101, 2'($urandom_range(0, 3))};
    else if (r < 95)                c = {3'b100, 2'($urandom_range(0, 3))};
    else                            c = 5'(26 + $urandom_range(0, 5));
    return c;
  endfunction

  int base, s_edge, d0;
  logic [14:0] exp3[4];
  logic [14:0] exp4[3];

  initial begin
    exp3[0] = {7'h40, 8'h85}; exp3[1] = {7'h41, 8'h85};
    exp3[2] = {7'h42, 8'h85}; exp3[3] = {7'h43, 8'h00};
    exp4[0] = {7'h40, 8'h80}; exp4[1] = {7'h41, 8'h80}; exp4[2] = {7'h42, 8'h00};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_addr", 32'(wr_bus.addr), 32'h00);
    chk("rst_wdata", 32'(wr_bus.wdata), 32'h00);
    chk("rst_wren", 32'(wr_bus.wren), 32'd0);
    chk("rst_recording", 32'(recording), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_song", 32'(song), 32'd1);
    reset_n = 1'b1;
    cyc(5'b00000);

    // song select in IDLE
    cyc(5'b10110);
    cyc(5'b00000);
    chk("sel_song", 32'(song), 32'd2);
    chk("sel_no_write", 32'(wlog.size()), 32'd0);

    // held key, stop after three beats
    base = wlog.size(); d0 = done_cnt;
    cyc(5'b11000);
    s_edge = cyc_cnt;
    wait_log(base + 3, 5'b00101, "t3_timeout");
    cyc(5'b11001);
    cyc(5'b00000);
    cyc(5'b00000);
    chk("t3_count", 32'(wlog.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < wlog.size()) chk($sformatf("t3_word%0d", i), 32'(wlog[base + i]), 32'(exp3[i]));
    if (wcyc.size() > base) chk("t3_first_beat", 32'(wcyc[base] - s_edge), 32'(B));
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_idle", 32'(recording), 32'd0);

    // no keys: rests then terminator
    base = wlog.size();
    cyc(5'b11000);
    wait_log(base + 2, 5'b00000, "t4_timeout");
    cyc(5'b11001);
    cyc(5'b00000);
    cyc(5'b00000);
    chk("t4_count", 32'(wlog.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < wlog.size()) chk($sformatf("t4_word%0d", i), 32'(wlog[base + i]), 32'(exp4[i]));

    // never stopped: 31 notes then marker at slot 31
    base = wlog.size(); d0 = done_cnt;
    cyc(5'b11000);
    for (int i = 0; i < 40 * B && done_cnt == d0; i++) cyc(rnd_code(1'b0));
    chk("t5_done_seen", 32'(done_cnt - d0), 32'd1);
    repeat (2 * B) cyc(5'b00000);
    chk("t5_count", 32'(wlog.size() - base), 32'd32);
    if (wlog.size() >= base + 32) begin
      for (int i = 0; i < 31; i++) begin
        chk($sformatf("t5_addr%0d", i), 32'(wlog[base + i][14:8]), 32'({2'b10, 5'(i)}));
        chk($sformatf("t5_valid%0d", i), 32'(wlog[base + i][7]), 32'd1);
      end
      chk("t5_marker", 32'(wlog[base + 31]), 32'({7'h5F, 8'h00}));
    end

    // stop on the tick cycle with a pending key
    base = wlog.size();
    cyc(5'b11000);
    wait_log(base + 1, 5'b00000, "t6_timeout");
    repeat (B - 1) cyc(5'b00011);
    cyc(5'b11001);
    cyc(5'b00000);
    cyc(5'b00000);
    chk("t6_count", 32'(wlog.size() - base), 32'd3);
    if (wlog.size() >= base + 3) begin
      chk("t6_note", 32'(wlog[base + 1]), 32'({7'h41, 8'h83}));
      chk("t6_marker", 32'(wlog[base + 2]), 32'({7'h42, 8'h00}));
      chk("t6_adjacent", 32'(wcyc[base + 2] - wcyc[base + 1]), 32'd1);
    end

    // song select ignored in REC, then reset mid-take
    base = wlog.size(); d0 = done_cnt;
    cyc(5'b11000);
    cyc(5'b00000);
    cyc(5'b10100);
    chk("t7_sel_ignored", 32'(song), 32'd2);
    wait_log(base + 2, 5'b00111, "t7_timeout");
    reset_n = 1'b0;
    #1;
    chk("t7_addr", 32'(wr_bus.addr), 32'h00);
    chk("t7_wdata", 32'(wr_bus.wdata), 32'h00);
    chk("t7_wren", 32'(wr_bus.wren), 32'd0);
    chk("t7_recording", 32'(recording), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_song", 32'(song), 32'd1);
    repeat (3) cyc(5'b00000);
    reset_n = 1'b1;
    repeat (3 * B) cyc(5'b00000);
    chk("t7_no_marker", 32'(wlog.size() - base), 32'd2);
    chk("t7_no_done", 32'(done_cnt - d0), 32'd0);

    // random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) cyc(rnd_code(1'b1));
    repeat (40 * B) cyc(5'b11001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
